// File: rtl/nanorv32_code_mem_loader_arb_pkg.sv
// Shared constants for the code-memory loader/arbiter: FSM state encodings
// and the word-index width derived from the byte-address width.
package nanorv32_code_mem_loader_arb_pkg;

    localparam logic [1:0] NANORV32_LDARB_IDLE    = 2'd0;
    localparam logic [1:0] NANORV32_LDARB_COLLECT = 2'd1;
    localparam logic [1:0] NANORV32_LDARB_WRITE   = 2'd2;
    localparam logic [1:0] NANORV32_LDARB_DONE    = 2'd3;

    // Memory is word-organised; the two byte-offset bits are dropped.
    function automatic int word_idx_width(input int addr_size);
        return addr_size - 2;
    endfunction

endpackage

// File: rtl/nanorv32_byte_packer.sv
// Packs loader bytes little-endian into a 32-bit word; unfilled lanes stay
// zero because the register is cleared after every word is consumed.
module nanorv32_byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_in,
    input  logic        last_in,
    output logic        word_full,
    output logic        word_last,
    output logic [31:0] word_out
);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;
    logic        last_q, last_d;

    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        last_d = last_q;
        if (clear) begin
            cnt_d  = 2'd0;
            word_d = 32'd0;
            last_d = 1'b0;
        end else if (accept) begin
            word_d[{cnt_q, 3'b000} +: 8] = byte_in;
            cnt_d  = cnt_q + 2'd1;
            last_d = last_in;
        end
    end

    assign word_full = accept & ((cnt_q == 2'd3) | last_in);
    assign word_last = last_q;
    assign word_out  = word_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 2'd0;
            word_q <= 32'd0;
            last_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/nanorv32_code_mem_loader_arb.sv
// Arbitrates the single-port code RAM between instruction fetch and a
// byte-serial program loader. Optional NANORV32_LOADER_CHECKSUM_EN adds ld_checksum.
module nanorv32_code_mem_loader_arb
    import nanorv32_code_mem_loader_arb_pkg::*;
#(
    parameter int ADDR_SIZE        = 16,
    parameter int HOLD_AFTER_RESET = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cpu_req,
    input  logic [ADDR_SIZE-1:0] cpu_addr,
    output logic                 cpu_gnt,
    output logic                 cpu_rvalid,
    output logic [31:0]          cpu_rdata,
    output logic                 cpu_hold,
    input  logic                 ld_start,
    input  logic                 ld_valid,
    input  logic [7:0]           ld_byte,
    input  logic                 ld_last,
    output logic                 ld_ready,
    output logic                 ld_done,
    output logic                 ld_err,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_SIZE-3:0] mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata
`ifdef NANORV32_LOADER_CHECKSUM_EN
    ,
    output logic [31:0]          ld_checksum
`endif
);

    localparam int             WW        = word_idx_width(ADDR_SIZE);
    localparam logic [WW-1:0]  LAST_WORD = '1;
    localparam logic           HOLD_INIT = (HOLD_AFTER_RESET != 0);

    logic [1:0]    state_q, state_d;
    logic [WW-1:0] ptr_q, ptr_d;
    logic          hold_q, hold_d;
    logic          err_q, err_d;
    logic          rvalid_q, rvalid_d;

    logic          pk_clear;
    logic          pk_accept;
    logic          pk_full;
    logic          pk_last;
    logic [31:0]   pk_word;

    logic          unused_addr_bits;
    assign unused_addr_bits = ^cpu_addr[1:0];

    assign pk_accept = ld_valid & ld_ready;

    nanorv32_byte_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (pk_clear),
        .accept    (pk_accept),
        .byte_in   (ld_byte),
        .last_in   (ld_last),
        .word_full (pk_full),
        .word_last (pk_last),
        .word_out  (pk_word)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        err_d     = err_q;
        rvalid_d  = 1'b0;
        pk_clear  = 1'b0;
        cpu_gnt   = 1'b0;
        ld_ready  = 1'b0;
        ld_done   = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 32'd0;
        case (state_q)
            NANORV32_LDARB_IDLE: begin
                // A load request pre-empts a fetch issued in the same cycle.
                if (ld_start) begin
                    ptr_d    = '0;
                    err_d    = 1'b0;
                    hold_d   = 1'b1;
                    pk_clear = 1'b1;
                    state_d  = NANORV32_LDARB_COLLECT;
                end else if (cpu_req) begin
                    cpu_gnt  = 1'b1;
                    mem_en   = 1'b1;
                    mem_addr = cpu_addr[ADDR_SIZE-1:2];
                    rvalid_d = 1'b1;
                end
            end
            NANORV32_LDARB_COLLECT: begin
                ld_ready = 1'b1;
                if (pk_full) begin
                    state_d = NANORV32_LDARB_WRITE;
                end
            end
            NANORV32_LDARB_WRITE: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = ptr_q;
                mem_wdata = pk_word;
                pk_clear  = 1'b1;
                if (ptr_q == LAST_WORD) begin
                    ptr_d = '0;
                    err_d = 1'b1;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
                state_d = pk_last ? NANORV32_LDARB_DONE : NANORV32_LDARB_COLLECT;
            end
            NANORV32_LDARB_DONE: begin
                ld_done = 1'b1;
                hold_d  = 1'b0;
                state_d = NANORV32_LDARB_IDLE;
            end
            default: state_d = NANORV32_LDARB_IDLE;
        endcase
    end

    assign cpu_rvalid = rvalid_q;
    assign cpu_rdata  = rvalid_q ? mem_rdata : 32'd0;
    assign cpu_hold   = hold_q;
    assign ld_err     = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= NANORV32_LDARB_IDLE;
            ptr_q    <= '0;
            hold_q   <= HOLD_INIT;
            err_q    <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            hold_q   <= hold_d;
            err_q    <= err_d;
            rvalid_q <= rvalid_d;
        end
    end

`ifdef NANORV32_LOADER_CHECKSUM_EN
    logic [31:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (state_q == NANORV32_LDARB_IDLE && ld_start) begin
            sum_d = 32'd0;
        end else if (state_q == NANORV32_LDARB_WRITE) begin
            sum_d = sum_q + pk_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= 32'd0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign ld_checksum = sum_q;
`endif

endmodule

// File: tb/tb_nanorv32_code_mem_loader_arb.sv
// Directed bench: a 16-bit-address instance checked cycle by cycle from a
// vector table, plus a 4-word instance for pointer wrap and ld_err.
module tb_nanorv32_code_mem_loader_arb;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        cpu_req  = 1'b0;
    logic [15:0] cpu_addr = 16'd0;
    logic        ld_start = 1'b0;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_byte  = 8'd0;
    logic        ld_last  = 1'b0;

    logic        gnt16, rvalid16, hold16, ready16, done16, err16, en16, we16;
    logic [31:0] rdata16, wdata16, mrdata16;
    logic [13:0] maddr16;
    logic        gnt4, rvalid4, hold4, ready4, done4, err4, en4, we4;
    logic [31:0] rdata4, wdata4, mrdata4;
    logic [1:0]  maddr4;
`ifdef NANORV32_LOADER_CHECKSUM_EN
    logic [31:0] csum16, csum4;
`endif

    logic [31:0] mem16 [0:16383];
    logic [31:0] mem4  [0:3];
    int          writes16 = 0;

    int errors = 0;
    int checks = 0;

    nanorv32_code_mem_loader_arb #(.ADDR_SIZE(16), .HOLD_AFTER_RESET(0)) dut16 (
        .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
        .cpu_gnt(gnt16), .cpu_rvalid(rvalid16), .cpu_rdata(rdata16), .cpu_hold(hold16),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last),
        .ld_ready(ready16), .ld_done(done16), .ld_err(err16),
        .mem_en(en16), .mem_we(we16), .mem_addr(maddr16), .mem_wdata(wdata16),
        .mem_rdata(mrdata16)
`ifdef NANORV32_LOADER_CHECKSUM_EN
        , .ld_checksum(csum16)
`endif
    );

    nanorv32_code_mem_loader_arb #(.ADDR_SIZE(4), .HOLD_AFTER_RESET(0)) dut4 (
        .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_addr(cpu_addr[3:0]),
        .cpu_gnt(gnt4), .cpu_rvalid(rvalid4), .cpu_rdata(rdata4), .cpu_hold(hold4),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last),
        .ld_ready(ready4), .ld_done(done4), .ld_err(err4),
        .mem_en(en4), .mem_we(we4), .mem_addr(maddr4), .mem_wdata(wdata4),
        .mem_rdata(mrdata4)
`ifdef NANORV32_LOADER_CHECKSUM_EN
        , .ld_checksum(csum4)
`endif
    );

    // Synchronous single-port RAM models with registered read data.
    always @(posedge clk) begin
        if (en16) begin
            if (we16) begin
                mem16[maddr16] <= wdata16;
                writes16       <= writes16 + 1;
            end else begin
                mrdata16 <= mem16[maddr16];
            end
        end
        if (en4) begin
            if (we4) mem4[maddr4] <= wdata4;
            else     mrdata4 <= mem4[maddr4];
        end
    end

    typedef struct {
        logic        req;
        logic [15:0] addr;
        logic        start;
        logic        valid;
        logic [7:0]  b;
        logic        last;
        logic [84:0] exp;
    } vec_t;

    vec_t vecs [16];

    function automatic vec_t row(
        input logic req, input logic [15:0] addr, input logic start,
        input logic valid, input logic [7:0] b, input logic last,
        input logic gnt, input logic rv, input logic [31:0] rdata,
        input logic hold, input logic rdy, input logic done,
        input logic en, input logic we, input logic [13:0] maddr,
        input logic [31:0] wdata);
        vec_t v;
        v.req = req; v.addr = addr; v.start = start;
        v.valid = valid; v.b = b; v.last = last;
        v.exp = {gnt, rv, rdata, hold, rdy, done, en, we, maddr, wdata};
        return v;
    endfunction

    function automatic logic [31:0] pack4(input logic [7:0] base);
        logic [7:0] b0, b1, b2, b3;
        b0 = base; b1 = base + 8'd1; b2 = base + 8'd2; b3 = base + 8'd3;
        return {b3, b2, b1, b0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        ld_start = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int n;
        n = 0;
        @(negedge clk);
        ld_valid = 1'b1;
        ld_byte  = b;
        ld_last  = last;
        #1;
        while (!ready16 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 20) begin
            errors++;
            checks++;
            $display("FAIL ld_ready_timeout: got 0 expected 1");
        end
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    // Returns the number of falling edges from the final byte to ld_done.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            #1;
            if (done16) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        logic [84:0] act;
        int          lat;
        int          snap;

        mem16[2] = 32'hDEADBEEF;
        mem16[0] = 32'h0;

        vecs[0]  = row(0, 16'h0000, 0, 0, 8'h00, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 14'h0, 32'h0);
        vecs[1]  = row(1, 16'h0008, 0, 0, 8'h00, 0, 1, 0, 32'h0,        0, 0, 0, 1, 0, 14'h2, 32'h0);
        vecs[2]  = row(0, 16'h0000, 0, 0, 8'h00, 0, 0, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0, 14'h0, 32'h0);
        vecs[3]  = row(1, 16'h0010, 1, 0, 8'h00, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 14'h0, 32'h0);
        vecs[4]  = row(1, 16'h0010, 0, 0, 8'h00, 0, 0, 0, 32'h0,        1, 1, 0, 0, 0, 14'h0, 32'h0);
        vecs[5]  = row(0, 16'h0000, 0, 1, 8'h13, 0, 0, 0, 32'h0,        1, 1, 0, 0, 0, 14'h0, 32'h0);
        vecs[6]  = row(0, 16'h0000, 0, 1, 8'h05, 0, 0, 0, 32'h0,        1, 1, 0, 0, 0, 14'h0, 32'h0);
        vecs[7]  = row(0, 16'h0000, 0, 1, 8'h10, 0, 0, 0, 32'h0,        1, 1, 0, 0, 0, 14'h0, 32'h0);
        vecs[8]  = row(0, 16'h0000, 0, 1, 8'h00, 0, 0, 0, 32'h0,        1, 1, 0, 0, 0, 14'h0, 32'h0);
        vecs[9]  = row(0, 16'h0000, 0, 0, 8'h00, 0, 0, 0, 32'h0,        1, 0, 0, 1, 1, 14'h0, 32'h00100513);
        vecs[10] = row(0, 16'h0000, 0, 1, 8'h6F, 0, 0, 0, 32'h0,        1, 1, 0, 0, 0, 14'h0, 32'h0);
        vecs[11] = row(0, 16'h0000, 0, 1, 8'h00, 1, 0, 0, 32'h0,        1, 1, 0, 0, 0, 14'h0, 32'h0);
        vecs[12] = row(0, 16'h0000, 0, 0, 8'h00, 0, 0, 0, 32'h0,        1, 0, 0, 1, 1, 14'h1, 32'h0000006F);
        vecs[13] = row(0, 16'h0000, 0, 0, 8'h00, 0, 0, 0, 32'h0,        1, 0, 1, 0, 0, 14'h0, 32'h0);
        vecs[14] = row(1, 16'h0004, 0, 0, 8'h00, 0, 1, 0, 32'h0,        0, 0, 0, 1, 0, 14'h1, 32'h0);
        vecs[15] = row(0, 16'h0000, 0, 0, 8'h00, 0, 0, 1, 32'h0000006F, 0, 0, 0, 0, 0, 14'h0, 32'h0);

        repeat (3) @(negedge clk);
        #1;
        check("reset_hold", {31'd0, hold16}, 32'd0);
        check("reset_err",  {31'd0, err16},  32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            cpu_req  = vecs[i].req;
            cpu_addr = vecs[i].addr;
            ld_start = vecs[i].start;
            ld_valid = vecs[i].valid;
            ld_byte  = vecs[i].b;
            ld_last  = vecs[i].last;
            #1;
            act = {gnt16, rvalid16, rdata16, hold16, ready16, done16, en16, we16, maddr16, wdata16};
            checks++;
            if (act !== vecs[i].exp) begin
                errors++;
                $display("FAIL vec%0d: got %h expected %h", i, act, vecs[i].exp);
            end else begin
                $display("vec%0d ok outputs=%h", i, act);
            end
        end
        @(negedge clk);
        cpu_req = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
        check("mem16_word0", mem16[0], 32'h00100513);
        check("mem16_word1", mem16[1], 32'h0000006F);

        // 20 bytes into a 4-word memory: the fifth word overwrites word 0.
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            send_byte(8'(8'h40 + i), (i == 19));
        end
        wait_done(lat);
        $display("wrap load done latency=%0d", lat);
        check("done_latency", lat, 32'd2);
        check("done4_pulse", {31'd0, done4}, 32'd1);
        check("wrap_word0", mem4[0], pack4(8'h50));
        check("wrap_word1", mem4[1], pack4(8'h44));
        check("wrap_word2", mem4[2], pack4(8'h48));
        check("wrap_word3", mem4[3], pack4(8'h4C));
        check("wrap_err4",  {31'd0, err4},  32'd1);
        check("nowrap_err16", {31'd0, err16}, 32'd0);
        check("mem16_word4", mem16[4], pack4(8'h50));
        @(negedge clk);
        #1;
        check("hold_after_done", {31'd0, hold16}, 32'd0);

        pulse_start();
        #1;
        check("err4_cleared", {31'd0, err4}, 32'd0);
        check("ready_after_start", {31'd0, ready4}, 32'd1);
        send_byte(8'hAA, 1'b1);
        wait_done(lat);
        check("short_done_latency", lat, 32'd2);
        check("mem16_short_word", mem16[0], 32'h000000AA);

        // Reset in the middle of a word: nothing is written, FSM back to IDLE.
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        snap = writes16;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_hold",  {31'd0, hold16},  32'd0);
        check("abort_ready", {31'd0, ready16}, 32'd0);
        check("abort_we",    {31'd0, we16},    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("abort_writes", writes16, snap);
        check("abort_word0", mem16[0], 32'h000000AA);
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_addr = 16'h0000;
        #1;
        check("abort_idle_gnt", {31'd0, gnt16}, 32'd1);
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        check("abort_idle_rdata", rdata16, 32'h000000AA);

`ifdef NANORV32_LOADER_CHECKSUM_EN
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'hFF, 1'b1);
        wait_done(lat);
        check("csum_done_latency", lat, 32'd2);
        check("checksum", csum16, 32'h00000000);
        check("csum_word1", mem16[1], 32'hFFFFFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
